mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of one mem_block instance (single-port, 1-cycle registered read).
//  Port 0 = data/LSU side, port 1 = instruction-fetch side.
//  Selects at most one request per cycle, drives the mem_block command, and routes the registered read data back.
//  Also generates a per-port response pulse. Out-of-range addresses are trapped without a memory access.
// PARAMETERS
//  DEPTH    512  mem_block word count (passed through to the mem_block instance)
//  WIDTH    4    bytes per word; bytemask width
//  ADDR_W   $clog2(DEPTH*WIDTH)  byte-address width of the mem_block addr_i
// PORTS
//  clk            in   1       single clock, all logic on posedge
//  rst_n_i        in   1       asynchronous active-low reset
//  req_valid_i    in   2       per-port request valid (bit n = port n)
//  req_we_i       in   2       per-port 1=write, 0=read
//  req_addr0_i    in   32      port 0 byte address
//  req_addr1_i    in   32      port 1 byte address
//  req_wdata0_i   in   32      port 0 write data
//  req_wdata1_i   in   32      port 1 write data
//  req_mask0_i    in   WIDTH   port 0 byte mask
//  req_mask1_i    in   WIDTH   port 1 byte mask
//  gnt_o          out  2       one-hot/zero; request of port n accepted this cycle
//  rsp_valid_o    out  2       one-hot/zero; response for port n (1 cycle after its grant)
//  rsp_err_o      out  1       qualifies rsp_valid_o: address was out of range
//  rsp_rdata_o    out  32      read data (valid with rsp_valid_o for reads, else 0)
//  mem_addr_o     out  ADDR_W  to mem_block addr_i
//  mem_wdata_o    out  32      to mem_block wr_data_i
//  mem_mask_o     out  WIDTH   to mem_block bytemask_i
//  mem_we_o       out  1       to mem_block write_en_i
//  mem_re_o       out  1       to mem_block read_en_i
// BEHAVIOUR
//  - Reset: all outputs 0, rsp pipeline register cleared, RR pointer = port 0.
//  - Grant is combinational from req_valid_i and the RR pointer. Request is consumed at the posedge where gnt_o[n]=1.
//    Requester holds valid/addr/data stable until granted.
//  - mem_* outputs are combinational from the granted port. With no grant, mem_we_o and mem_re_o are 0 and addr/wdata/mask are 0.
//  - In range: addr[31:ADDR_W]==0. Granted read: mem_re_o=1. Granted write: mem_we_o=1 and mem_mask_o=mask.
//  - Out of range: grant still given, mem_re_o=mem_we_o=0, and the response carries rsp_err_o=1 with rdata 0.
//  - Response stage, one registered state {valid, port, is_read, err}:
//    - Cycle t+1 after grant: rsp_valid_o[port]=1.
//    - rsp_rdata_o = mem rd_data when is_read && !err, else 0.
//  - Fully pipelined: back-to-back grants every cycle, no bubbles. A read granted the cycle after a write to the same word returns the new data.
//  - Arbitration when both ports are valid: see CONFIGURATION. A single valid port is always granted immediately.
//  - Async reset mid-transaction drops any pending response; rsp_valid_o=0 the cycle reset releases.
//  - Masks: a write with mask==0 is granted and responded to, but leaves memory unchanged. Low addr bits below $clog2(WIDTH) are passed unchanged (mem_block ignores them).
// CONFIGURATION
//  MEM_ARBITER_RR_EN defined:
//    - Round-robin. On contention, grant the port != last-granted port.
//    - The pointer updates only on a grant.
//  MEM_ARBITER_RR_EN undefined:
//    - Fixed priority, port 0 always wins contention.
//    - The RR pointer register is not built.
// STRUCTURE
//  - Shared package mem_pkg holds:
//    - localparams PORT_DATA=0 and PORT_FETCH=1
//    - typedef rsp_stage_t {valid, port, is_read, err}
//    - function in_range(addr, ADDR_W)
//  - One sub-module, mem_arb_sel: pure combinational 2-way grant selector (RR or fixed), reused by future arbiters.
//  - mem_block is instantiated by the parent, not inside this block.
// TESTING
//  - Bench instantiates mem_arbiter + mem_block(DEPTH=512,WIDTH=4) with a reference model.
//  1. Reset: hold rst_n_i=0 with req_valid_i=2'b11 -> gnt_o=0, rsp_valid_o=0, mem_we_o=mem_re_o=0.
//  2. Write/read: port0 write addr 0x10, data 0xDEADBEEF, mask 4'hF; next cycle port0 read 0x10
//     -> rsp_rdata_o=0xDEADBEEF one cycle after the read grant.
//  3. Byte mask: write 0x11223344 mask 4'b0101 over 0xDEADBEEF, then read -> 0xDE22BE44.
//  4. Contention: both ports request reads continuously for 6 cycles.
//     -> RR_EN: gnt_o = 01,10,01,10,...; without RR_EN: gnt_o = 01 every cycle, port 1 starved.
//  5. Out of range: port1 read at 0x0000_1000 (ADDR_W=11)
//     -> gnt_o=10, mem_re_o=0, next cycle rsp_valid_o=10, rsp_err_o=1, rdata=0.
//  6. Reset mid-flight: assert rst_n_i low the cycle after a read grant -> no rsp_valid_o ever issued for it.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter.
//   PORT_DATA / PORT_FETCH : requester indices (LSU side, instruction-fetch side)
//   rsp_stage_t            : registered response-stage state
//   in_range()             : true when a byte address fits in an ADDR_W-bit memory
package mem_pkg;

  localparam logic PORT_DATA  = 1'b0;
  localparam logic PORT_FETCH = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
    logic err;
  } rsp_stage_t;

  // Every address bit at or above aw must be zero.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Two-way combinational grant selector.
//   req_i  : per-port request (bit n = port n)
//   prio_i : port that wins when both request (tie to 0 for fixed priority)
//   gnt_o  : one-hot/zero grant
// A lone requester is always granted; prio_i only breaks ties.
module mem_arb_sel (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port mem_block with a
// 1-cycle registered read. Port 0 = data/LSU, port 1 = instruction fetch.
//
// Build option: define MEM_ARBITER_RR_EN for round-robin tie-breaking;
// otherwise port 0 wins every contention and no pointer register is built.
//
// Ports:
//   clk, rst_n_i                 clock, asynchronous active-low reset
//   req_valid_i / req_we_i       per-port valid and write-enable
//   req_addr{0,1}_i              per-port byte address
//   req_wdata{0,1}_i             per-port write data
//   req_mask{0,1}_i              per-port byte mask
//   gnt_o                        request of port n accepted this cycle
//   rsp_valid_o / rsp_err_o      response pulse one cycle after grant, error flag
//   rsp_rdata_o                  read data for in-range reads, else 0
//   mem_addr_o .. mem_re_o       command to mem_block
//   mem_rdata_i                  mem_block rd_data (registered read result)
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH * WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic [1:0]        req_valid_i,
  input  logic [1:0]        req_we_i,
  input  logic [31:0]       req_addr0_i,
  input  logic [31:0]       req_addr1_i,
  input  logic [31:0]       req_wdata0_i,
  input  logic [31:0]       req_wdata1_i,
  input  logic [WIDTH-1:0]  req_mask0_i,
  input  logic [WIDTH-1:0]  req_mask1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rsp_valid_o,
  output logic              rsp_err_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [WIDTH-1:0]  mem_mask_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [31:0]       mem_rdata_i
);

  logic [1:0]       req_act;
  logic [1:0]       gnt;
  logic             prio;
  logic             sel_port;
  logic             sel_we;
  logic             sel_ok;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [WIDTH-1:0] sel_mask;
  rsp_stage_t       rsp_d, rsp_q;

  // Requests are masked while reset is held so every output reads 0.
  assign req_act = rst_n_i ? req_valid_i : 2'b00;

  mem_arb_sel u_sel (
    .req_i  (req_act),
    .prio_i (prio),
    .gnt_o  (gnt)
  );

  assign gnt_o = gnt;

`ifdef MEM_ARBITER_RR_EN
  // Port favoured on the next contention; flips away from each granted port.
  logic prio_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prio_q <= PORT_DATA;
    end else if (|gnt) begin
      prio_q <= ~gnt[PORT_FETCH];
    end
  end

  assign prio = prio_q;
`else
  assign prio = PORT_DATA;
`endif

  // Command path: mux the granted port onto the mem_block interface.
  always_comb begin
    sel_port  = gnt[PORT_FETCH];
    sel_we    = sel_port ? req_we_i[1]  : req_we_i[0];
    sel_addr  = sel_port ? req_addr1_i  : req_addr0_i;
    sel_wdata = sel_port ? req_wdata1_i : req_wdata0_i;
    sel_mask  = sel_port ? req_mask1_i  : req_mask0_i;
    sel_ok    = in_range(sel_addr, ADDR_W);

    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_mask_o  = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    if (|gnt) begin
      mem_addr_o = sel_addr[ADDR_W-1:0];
      // Out-of-range requests are granted but never touch memory.
      if (sel_ok) begin
        if (sel_we) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = sel_wdata;
          mem_mask_o  = sel_mask;
        end else begin
          mem_re_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rsp_d         = '0;
    rsp_d.valid   = |gnt;
    rsp_d.port    = sel_port;
    rsp_d.is_read = (|gnt) & ~sel_we;
    rsp_d.err     = (|gnt) & ~sel_ok;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Response outputs; rd_data arrives from mem_block in the same cycle as rsp_q.
  always_comb begin
    rsp_valid_o = 2'b00;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    if (rsp_q.valid) begin
      rsp_valid_o = (rsp_q.port == PORT_FETCH) ? 2'b10 : 2'b01;
      rsp_err_o   = rsp_q.err;
      if (rsp_q.is_read && !rsp_q.err) begin
        rsp_rdata_o = mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural single-port memory
// (1-cycle registered read, byte-masked write) standing in for mem_block.
module tb_mem_arbiter;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned WIDTH  = 4;
  localparam int unsigned ADDR_W = 11;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [31:0]       req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [WIDTH-1:0]  req_mask0, req_mask1;
  logic [1:0]        gnt;
  logic [1:0]        rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [WIDTH-1:0]  mem_mask;
  logic              mem_we, mem_re;
  logic [31:0]       mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_we_i     (req_we),
    .req_addr0_i  (req_addr0),
    .req_addr1_i  (req_addr1),
    .req_wdata0_i (req_wdata0),
    .req_wdata1_i (req_wdata1),
    .req_mask0_i  (req_mask0),
    .req_mask1_i  (req_mask1),
    .gnt_o        (gnt),
    .rsp_valid_o  (rsp_valid),
    .rsp_err_o    (rsp_err),
    .rsp_rdata_o  (rsp_rdata),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_mask_o   (mem_mask),
    .mem_we_o     (mem_we),
    .mem_re_o     (mem_re),
    .mem_rdata_i  (mem_rdata)
  );

  // Behavioural mem_block.
  logic [31:0] mem_arr [DEPTH];
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (mem_mask[b]) mem_arr[mem_addr[ADDR_W-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_re) mem_rdata <= mem_arr[mem_addr[ADDR_W-1:2]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  mask0, mask1;
    logic [1:0]  e_gnt;
    logic        e_re, e_we;
    logic [10:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [1:0]  e_rsp;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_addr0  = '0;
    req_addr1  = '0;
    req_wdata0 = '0;
    req_wdata1 = '0;
    req_mask0  = '0;
    req_mask1  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] v, input logic [1:0] w,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [3:0] m0, input logic [3:0] m1,
                              input logic [1:0] g, input logic re, input logic we,
                              input logic [10:0] ea, input logic [3:0] em,
                              input logic [31:0] ed, input logic [1:0] rv,
                              input logic er, input logic [31:0] rd);
    vec_t t;
    t.name = n; t.valid = v; t.we = w; t.addr0 = a0; t.addr1 = a1;
    t.wdata0 = d0; t.wdata1 = d1; t.mask0 = m0; t.mask1 = m1;
    t.e_gnt = g; t.e_re = re; t.e_we = we; t.e_addr = ea; t.e_mask = em;
    t.e_wdata = ed; t.e_rsp = rv; t.e_err = er; t.e_rdata = rd;
    return t;
  endfunction

  logic [1:0] exp_gnt;

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset with both ports requesting: nothing granted, nothing issued.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("reset_gnt", {30'd0, gnt}, 32'd0);
    chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_mem_re", {31'd0, mem_re}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-requester traffic (no contention, so config-independent).
    //          name        valid  we     addr0          addr1          wdata0        wdata1        m0    m1    gnt re we addr     mask  wdata         rsp   err rdata
    vecs[0]  = mk("wr0",    2'b01, 2'b01, 32'h10,        0,             32'hDEADBEEF, 0,            4'hF, 0,    1, 0, 1, 11'h010, 4'hF, 32'hDEADBEEF, 2'b01, 0, 0);
    vecs[1]  = mk("rd0",    2'b01, 2'b00, 32'h10,        0,             0,            0,            0,    0,    1, 1, 0, 11'h010, 4'h0, 0,            2'b01, 0, 32'hDEADBEEF);
    vecs[2]  = mk("wrmask", 2'b01, 2'b01, 32'h10,        0,             32'h11223344, 0,            4'h5, 0,    1, 0, 1, 11'h010, 4'h5, 32'h11223344, 2'b01, 0, 0);
    vecs[3]  = mk("rdmask", 2'b01, 2'b00, 32'h10,        0,             0,            0,            0,    0,    1, 1, 0, 11'h010, 4'h0, 0,            2'b01, 0, 32'hDE22BE44);
    vecs[4]  = mk("wr1",    2'b10, 2'b10, 0,             32'h20,        0,            32'hCAFEF00D, 0,    4'hF, 2, 0, 1, 11'h020, 4'hF, 32'hCAFEF00D, 2'b10, 0, 0);
    vecs[5]  = mk("rd1",    2'b10, 2'b00, 0,             32'h20,        0,            0,            0,    0,    2, 1, 0, 11'h020, 4'h0, 0,            2'b10, 0, 32'hCAFEF00D);
    vecs[6]  = mk("oor_rd1",2'b10, 2'b00, 0,             32'h1000,      0,            0,            0,    0,    2, 0, 0, 11'h000, 4'h0, 0,            2'b10, 1, 0);
    vecs[7]  = mk("wr_m0",  2'b01, 2'b01, 32'h20,        0,             32'hFFFFFFFF, 0,            4'h0, 0,    1, 0, 1, 11'h020, 4'h0, 32'hFFFFFFFF, 2'b01, 0, 0);
    vecs[8]  = mk("rd_m0",  2'b10, 2'b00, 0,             32'h20,        0,            0,            0,    0,    2, 1, 0, 11'h020, 4'h0, 0,            2'b10, 0, 32'hCAFEF00D);
    vecs[9]  = mk("idle",   2'b00, 2'b00, 0,             0,             0,            0,            0,    0,    0, 0, 0, 11'h000, 4'h0, 0,            2'b00, 0, 0);
    vecs[10] = mk("oor_wr0",2'b01, 2'b01, 32'h80000010,  0,             32'h12345678, 0,            4'hF, 0,    1, 0, 0, 11'h010, 4'h0, 0,            2'b01, 1, 0);
    vecs[11] = mk("rd_low", 2'b01, 2'b00, 32'h13,        0,             0,            0,            0,    0,    1, 1, 0, 11'h013, 4'h0, 0,            2'b01, 0, 32'hDE22BE44);
    vecs[12] = mk("rd_wr0", 2'b01, 2'b00, 32'h10,        0,             0,            0,            0,    0,    1, 1, 0, 11'h010, 4'h0, 0,            2'b01, 0, 32'hDE22BE44);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req_valid  = vecs[i].valid;
      req_we     = vecs[i].we;
      req_addr0  = vecs[i].addr0;
      req_addr1  = vecs[i].addr1;
      req_wdata0 = vecs[i].wdata0;
      req_wdata1 = vecs[i].wdata1;
      req_mask0  = vecs[i].mask0;
      req_mask1  = vecs[i].mask1;
      #1;
      chk({vecs[i].name, "_gnt"},   {30'd0, gnt},      {30'd0, vecs[i].e_gnt});
      chk({vecs[i].name, "_re"},    {31'd0, mem_re},   {31'd0, vecs[i].e_re});
      chk({vecs[i].name, "_we"},    {31'd0, mem_we},   {31'd0, vecs[i].e_we});
      chk({vecs[i].name, "_addr"},  {21'd0, mem_addr}, {21'd0, vecs[i].e_addr});
      chk({vecs[i].name, "_mask"},  {28'd0, mem_mask}, {28'd0, vecs[i].e_mask});
      chk({vecs[i].name, "_wdata"}, mem_wdata,         vecs[i].e_wdata);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, vecs[i].e_rsp});
      chk({vecs[i].name, "_rsp_err"},   {31'd0, rsp_err},   {31'd0, vecs[i].e_err});
      chk({vecs[i].name, "_rsp_rdata"}, rsp_rdata,          vecs[i].e_rdata);
    end
    @(negedge clk);
    idle_inputs();

    // Contention right after reset: both ports read every cycle for 6 cycles.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr0 = 32'h10;
      req_addr1 = 32'h20;
`ifdef MEM_ARBITER_RR_EN
      exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      #1;
      chk($sformatf("contend_gnt_%0d", c), {30'd0, gnt}, {30'd0, exp_gnt});
      @(posedge clk);
      #1;
      chk($sformatf("contend_rsp_%0d", c), {30'd0, rsp_valid}, {30'd0, exp_gnt});
      @(negedge clk);
    end
    idle_inputs();

    // Reset asserted just after a read grant: its response must never appear.
    @(negedge clk);
    req_valid = 2'b01;
    req_addr0 = 32'h10;
    #1;
    chk("midrst_gnt", {30'd0, gnt}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_rsp_in_reset", {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_rsp_after_%0d", c), {30'd0, rsp_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
